// File: rtl/mpt_pkg.sv
// Shared constants and types for the MPT memory read path.
package mpt_pkg;

  localparam int unsigned MPT_MEM_ARB_NUM_REQ = 2;

  typedef logic [$clog2(MPT_MEM_ARB_NUM_REQ)-1:0] mpt_req_id_t;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with occupancy output and a synchronous flush.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 4,
  parameter type         dtype        = logic,
  localparam int unsigned ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [ADDR_W:0] usage_o,
  input  dtype            data_i,
  input  logic            push_i,
  output dtype            data_o,
  input  logic            pop_i
);

  dtype              mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              is_empty, bypass, do_push, do_pop;

  assign is_empty = (cnt_q == '0);
  assign full_o   = (cnt_q == (ADDR_W+1)'(DEPTH));
  assign empty_o  = is_empty && !(FALL_THROUGH && push_i);
  assign usage_o  = cnt_q;

  // In fall-through mode an empty FIFO can hand the input straight to the reader.
  assign bypass  = FALL_THROUGH && is_empty && push_i && pop_i;
  assign do_push = push_i && !full_o && !bypass;
  assign do_pop  = pop_i && !empty_o && !bypass;
  assign data_o  = (FALL_THROUGH && is_empty) ? data_i : mem_q[rd_ptr_q];

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == ADDR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == ADDR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: the storage array is not reset; pointers guarantee no entry is read before it is written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mpt_mem_read_arbiter.sv
// Round-robin arbiter sharing one read-only memory port between MPT walker read stages;
// responses are routed back in order using a FIFO of granted requester IDs.
module mpt_mem_read_arbiter
  import mpt_pkg::*;
#(
  parameter int unsigned NUM_REQ           = MPT_MEM_ARB_NUM_REQ,
  parameter int unsigned MAX_OUTSTANDING   = 4,
  parameter int unsigned MEMORY_DATA_WIDTH = 32,
  parameter int unsigned MEMORY_ADDR_WIDTH = 32,
  localparam int unsigned ID_W             = $clog2(NUM_REQ),
  localparam int unsigned CNT_W            = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NUM_REQ-1:0]                         req_mem_req_i,
  input  logic [NUM_REQ-1:0][MEMORY_ADDR_WIDTH-1:0]  req_mem_addr_i,
  output logic [NUM_REQ-1:0]                         req_mem_gnt_o,
  output logic [NUM_REQ-1:0]                         req_mem_valid_o,
  output logic [MEMORY_DATA_WIDTH-1:0]               req_mem_rdata_o,
  output logic                                       memory_master_mem_req,
  input  logic                                       memory_master_mem_gnt,
  output logic [MEMORY_ADDR_WIDTH-1:0]               memory_master_mem_addr,
  output logic                                       memory_master_mem_we,
  output logic [MEMORY_DATA_WIDTH/8-1:0]             memory_master_mem_be,
  output logic [MEMORY_DATA_WIDTH-1:0]               memory_master_mem_wdata,
  input  logic                                       memory_master_mem_valid,
  input  logic [MEMORY_DATA_WIDTH-1:0]               memory_master_mem_rdata,
  output logic [CNT_W-1:0]                           outstanding_o,
  output logic                                       err_unexpected_o
);

  // Package ID type covers the default configuration; this one follows NUM_REQ.
  typedef logic [ID_W-1:0] req_id_t;

  req_id_t     rr_ptr_q, sel, rr_next, head_id;
  int unsigned idx;
  logic        any_req, id_full, id_empty, handshake, pop, err_q;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    sel = rr_ptr_q;
    idx = 0;
    // Scan from farthest to nearest so the closest requester after rr_ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (32'(rr_ptr_q) + 32'(k)) % NUM_REQ;
      if (req_mem_req_i[idx[ID_W-1:0]]) sel = idx[ID_W-1:0];
    end
  end

  assign rr_next   = (sel == req_id_t'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  assign any_req   = |req_mem_req_i;

  assign memory_master_mem_req  = rst_ni && any_req && !id_full;
  assign memory_master_mem_addr = any_req ? req_mem_addr_i[sel] : '0;
  assign handshake              = memory_master_mem_req && memory_master_mem_gnt;
  assign pop                    = rst_ni && memory_master_mem_valid && !id_empty;

  always_comb begin
    req_mem_gnt_o   = '0;
    req_mem_valid_o = '0;
    if (handshake) req_mem_gnt_o[sel]       = 1'b1;
    if (pop)       req_mem_valid_o[head_id] = 1'b1;
  end

  assign req_mem_rdata_o         = memory_master_mem_rdata;
  assign memory_master_mem_we    = 1'b0;
  assign memory_master_mem_be    = '0;
  assign memory_master_mem_wdata = '0;
  assign err_unexpected_o        = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (handshake) rr_ptr_q <= rr_next;
      if (memory_master_mem_valid && id_empty) err_q <= 1'b1;
    end
  end

  // Reset reaches the ID FIFO as a synchronous flush so it clears at the same edge as rr_ptr.
  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (MAX_OUTSTANDING),
    .dtype        (req_id_t)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (1'b1),
    .flush_i (!rst_ni),
    .full_o  (id_full),
    .empty_o (id_empty),
    .usage_o (outstanding_o),
    .data_i  (sel),
    .push_i  (handshake),
    .data_o  (head_id),
    .pop_i   (pop)
  );

endmodule

// File: tb/tb_mpt_mem_read_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_mpt_mem_read_arbiter;

  localparam int N    = 2;
  localparam int MAXO = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N-1:0][31:0] addr;
  logic [N-1:0]     gnt, valid;
  logic [31:0]      rdata;
  logic             mem_req, mgnt, mem_we, mvalid, err;
  logic [31:0]      mem_addr, mem_wdata, mrdata;
  logic [3:0]       mem_be;
  logic [2:0]       outstanding;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state: outstanding requester IDs, round-robin start, sticky error.
  int           mq[$];
  int           m_rr  = 0;
  bit           m_err = 1'b0;
  logic [N-1:0] m_gnt_last = '0;

  always #5 clk = ~clk;

  mpt_mem_read_arbiter dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .req_mem_req_i           (req),
    .req_mem_addr_i          (addr),
    .req_mem_gnt_o           (gnt),
    .req_mem_valid_o         (valid),
    .req_mem_rdata_o         (rdata),
    .memory_master_mem_req   (mem_req),
    .memory_master_mem_gnt   (mgnt),
    .memory_master_mem_addr  (mem_addr),
    .memory_master_mem_we    (mem_we),
    .memory_master_mem_be    (mem_be),
    .memory_master_mem_wdata (mem_wdata),
    .memory_master_mem_valid (mvalid),
    .memory_master_mem_rdata (mrdata),
    .outstanding_o           (outstanding),
    .err_unexpected_o        (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One model cycle: derive the expected outputs from the current inputs and model state,
  // compare, then advance the model to the state after the coming clock edge.
  task automatic model_cycle();
    int           sel;
    bit           full, exp_req, hs, pp;
    logic [N-1:0] exp_gnt, exp_valid;
    logic [31:0]  exp_addr;
    sel = m_rr;
    for (int k = 0; k < N; k++) begin
      int c = (m_rr + k) % N;
      if (req[c]) begin
        sel = c;
        break;
      end
    end
    full      = (mq.size() >= MAXO);
    exp_req   = rst_n && (req != '0) && !full;
    hs        = exp_req && mgnt;
    pp        = rst_n && mvalid && (mq.size() > 0);
    exp_gnt   = hs ? N'(1 << sel) : '0;
    exp_valid = pp ? N'(1 << mq[0]) : '0;
    exp_addr  = (req != '0) ? addr[sel] : 32'h0;

    check("m_mem_req", mem_req, exp_req);
    check("m_mem_addr", mem_addr, exp_addr);
    check("m_gnt", gnt, exp_gnt);
    check("m_valid", valid, exp_valid);
    check("m_rdata", rdata, mrdata);
    check("m_outstanding", outstanding, mq.size());
    check("m_err", err, m_err);
    check("m_tieoff", {mem_we, mem_be, mem_wdata}, '0);

    m_gnt_last = exp_gnt;
    if (!rst_n) begin
      mq.delete();
      m_rr  = 0;
      m_err = 1'b0;
    end else begin
      if (mvalid && mq.size() == 0) m_err = 1'b1;
      if (pp) void'(mq.pop_front());
      if (hs) begin
        mq.push_back(sel);
        m_rr = (sel + 1) % N;
      end
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_cycle();
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    mgnt   = 1'b0;
    mvalid = 1'b0;
    @(negedge clk);
    next();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    addr   = '0;
    mgnt   = 1'b0;
    mvalid = 1'b0;
    mrdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_outstanding", outstanding, 3'd0);
    check("rst_err", err, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    next();

    // Single requester: grant, one idle cycle, then the response.
    req = 2'b01; addr[0] = 32'h100; mgnt = 1'b1;
    @(negedge clk);
    check("t1_gnt", gnt, 2'b01);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_occ0", outstanding, 3'd0);
    next();
    req = 2'b00; mgnt = 1'b0;
    @(negedge clk);
    check("t1_occ1", outstanding, 3'd1);
    next();
    mvalid = 1'b1; mrdata = 32'hCAFE;
    @(negedge clk);
    check("t1_valid", valid, 2'b01);
    check("t1_rdata", rdata, 32'hCAFE);
    next();
    mvalid = 1'b0;
    @(negedge clk);
    check("t1_occ_end", outstanding, 3'd0);
    next();
    do_reset();

    // Fairness with both requesting, running straight into the full condition.
    req = 2'b11; addr[0] = 32'h10; addr[1] = 32'h20; mgnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0]  eg;
      logic [31:0] ea;
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      ea = (i % 2 == 0) ? 32'h10 : 32'h20;
      @(negedge clk);
      check("fair_gnt", gnt, eg);
      check("fair_addr", mem_addr, ea);
      next();
    end
    @(negedge clk);
    check("full_occ", outstanding, 3'd4);
    check("full_mem_req", mem_req, 1'b0);
    check("full_gnt", gnt, 2'b00);
    next();
    mvalid = 1'b1; mrdata = 32'h55;
    @(negedge clk);
    check("full_pop_valid", valid, 2'b01);
    check("full_pop_no_req", mem_req, 1'b0);
    check("full_pop_no_gnt", gnt, 2'b00);
    next();
    mvalid = 1'b0;
    @(negedge clk);
    check("full_after_occ", outstanding, 3'd3);
    check("full_after_req", mem_req, 1'b1);
    check("full_after_gnt", gnt, 2'b01);
    next();
    do_reset();

    // Ordering r1,r0,r1 with a same-cycle push/pop at occupancy 2.
    req = 2'b10; addr[1] = 32'h200; mgnt = 1'b1;
    @(negedge clk); check("ord_gnt0", gnt, 2'b10); next();
    req = 2'b01; addr[0] = 32'h300;
    @(negedge clk); check("ord_gnt1", gnt, 2'b01); next();
    req = 2'b10;
    @(negedge clk); check("ord_gnt2", gnt, 2'b10); next();
    req = 2'b00; mgnt = 1'b0; mvalid = 1'b1; mrdata = 32'hA;
    @(negedge clk);
    check("ord_valid_a", valid, 2'b10);
    check("ord_rdata_a", rdata, 32'hA);
    next();
    req = 2'b01; mgnt = 1'b1; mrdata = 32'hB;
    @(negedge clk);
    check("pp_occ_before", outstanding, 3'd2);
    check("pp_valid_b", valid, 2'b01);
    check("pp_gnt", gnt, 2'b01);
    next();
    req = 2'b00; mgnt = 1'b0; mrdata = 32'hC;
    @(negedge clk);
    check("pp_occ_after", outstanding, 3'd2);
    check("ord_valid_c", valid, 2'b10);
    check("ord_rdata_c", rdata, 32'hC);
    next();
    mrdata = 32'hD;
    @(negedge clk); check("pp_valid_new", valid, 2'b01); next();
    mvalid = 1'b0;
    @(negedge clk);
    check("ord_occ_end", outstanding, 3'd0);
    check("ord_err", err, 1'b0);
    next();

    // Unexpected response with nothing outstanding.
    mvalid = 1'b1; mrdata = 32'hDEAD;
    @(negedge clk);
    check("unexp_valid", valid, 2'b00);
    check("unexp_err_same", err, 1'b0);
    next();
    mvalid = 1'b0;
    @(negedge clk); check("unexp_err_set", err, 1'b1); next();
    repeat (3) next();
    @(negedge clk); check("unexp_err_sticky", err, 1'b1); next();
    do_reset();
    @(negedge clk); check("unexp_err_cleared", err, 1'b0); next();

    // Reset mid-operation discards the ID; the late response is flagged.
    req = 2'b01; addr[0] = 32'h400; mgnt = 1'b1;
    @(negedge clk); check("mid_gnt", gnt, 2'b01); next();
    do_reset();
    mvalid = 1'b1;
    @(negedge clk); check("mid_valid", valid, 2'b00); next();
    mvalid = 1'b0;
    @(negedge clk); check("mid_err", err, 1'b1); next();
    do_reset();

    // Randomized traffic; requesters hold req/addr until granted.
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < N; r++) begin
        if (!req[r] || m_gnt_last[r]) begin
          req[r]  = ($urandom % 3) != 0;
          addr[r] = $urandom;
        end
      end
      mgnt   = ($urandom % 4) != 0;
      mvalid = (mq.size() > 0) ? 1'($urandom % 2) : (($urandom % 200) == 0);
      mrdata = $urandom;
      rst_n  = ($urandom % 500) != 0;
      @(negedge clk);
      next();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
